// File: rtl/sim_ctrl_pkg.sv
// sim_ctrl_pkg
//   Shared types and widths for the distributed-sim run sequencer.
//   state_t      : run sequencer FSM states
//   end_cause_t  : reason a run ended (reported on end_cause_o)
//   CLK_CNT_W    : run-cycle counter width
//   EVT_CNT_W    : benchmark-event counter width
//   evt_sat_inc  : increment that sticks at all-ones
package sim_ctrl_pkg;

    localparam int CLK_CNT_W = 32;
    localparam int EVT_CNT_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_CYC   = 2'd1,
        CAUSE_EVT   = 2'd2,
        CAUSE_ABORT = 2'd3
    } end_cause_t;

    function automatic logic [EVT_CNT_W-1:0] evt_sat_inc(input logic [EVT_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + EVT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sim_run_ctrl_if.sv
// sim_run_ctrl_if
//   Control/status bundle between the sim top (master) and the run sequencer (slave).
//   start_i, abort_i, is_master_i, benchmark_i : master -> sequencer
//   dut_reset_n_o, running_o, done_o, finish_req_o,
//   clk_cnt_o, event_cnt_o, end_cause_o        : sequencer -> master
interface sim_run_ctrl_if;

    logic                                start_i;
    logic                                abort_i;
    logic                                is_master_i;
    logic                                benchmark_i;
    logic                                dut_reset_n_o;
    logic                                running_o;
    logic                                done_o;
    logic                                finish_req_o;
    logic [sim_ctrl_pkg::CLK_CNT_W-1:0]  clk_cnt_o;
    logic [sim_ctrl_pkg::EVT_CNT_W-1:0]  event_cnt_o;
    logic [1:0]                          end_cause_o;

    modport master (
        output start_i, abort_i, is_master_i, benchmark_i,
        input  dut_reset_n_o, running_o, done_o, finish_req_o,
               clk_cnt_o, event_cnt_o, end_cause_o
    );

    modport slave (
        input  start_i, abort_i, is_master_i, benchmark_i,
        output dut_reset_n_o, running_o, done_o, finish_req_o,
               clk_cnt_o, event_cnt_o, end_cause_o
    );

endinterface

// File: rtl/sim_evt_counter.sv
// sim_evt_counter
//   Rising-edge detector plus saturating event counter.
//   clk_i, reset_i : clock, synchronous active-high reset
//   en_i           : count detected edges this cycle
//   clr_i          : clear the count (wins over en_i)
//   benchmark_i    : raw benchmark level, registered every cycle
//   cnt_o          : registered count
//   cnt_nxt_o      : value cnt_o takes at the next edge (used for limit lookahead)
module sim_evt_counter
    import sim_ctrl_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 benchmark_i,
    output logic [EVT_CNT_W-1:0] cnt_o,
    output logic [EVT_CNT_W-1:0] cnt_nxt_o
);

    logic                 bench_q, bench_d;
    logic [EVT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 rise;

    always_comb begin
        bench_d = benchmark_i;
        rise    = benchmark_i & ~bench_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && rise) begin
            cnt_d = evt_sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bench_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            bench_q <= bench_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl
//   Run sequencer for one distributed-sim node: holds the DUT in reset after start,
//   runs until a cycle/event limit or abort, drains, then raises a one-shot finish
//   request (master node only).
//   clk_i, reset_i : clock, synchronous active-high reset
//   bus (slave)    : start/abort/is_master/benchmark in; DUT reset, status,
//                    run-cycle count, event count and end cause out
module sim_run_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = 11,
    parameter int MAX_CYCLES   = 200000,
    parameter int MAX_EVENTS   = 0,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic           clk_i,
    input  logic           reset_i,
    sim_run_ctrl_if.slave  bus
);

    localparam logic [CLK_CNT_W-1:0] RST_LAST   = CLK_CNT_W'(RST_CYCLES - 1);
    // A zero-length drain still spends one clock in DRAIN.
    localparam logic [CLK_CNT_W-1:0] DRAIN_LAST = CLK_CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [CLK_CNT_W-1:0] MAX_CYC    = CLK_CNT_W'(MAX_CYCLES);
    localparam logic [EVT_CNT_W-1:0] MAX_EVT    = EVT_CNT_W'(MAX_EVENTS);

    state_t               state_q, state_d;
    end_cause_t           cause_q, cause_d;
    logic [CLK_CNT_W-1:0] phase_q, phase_d;
    logic [CLK_CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic                 rstn_q, rstn_d;
    logic                 running_q, running_d;
    logic                 done_q, done_d;
    logic                 fin_q, fin_d;
    logic                 evt_en, evt_clr;
    logic                 hit_cyc, hit_evt;
    logic [EVT_CNT_W-1:0] evt_cnt, evt_nxt;

    sim_evt_counter u_evt (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .en_i        (evt_en),
        .clr_i       (evt_clr),
        .benchmark_i (bus.benchmark_i),
        .cnt_o       (evt_cnt),
        .cnt_nxt_o   (evt_nxt)
    );

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        phase_d   = phase_q;
        clk_cnt_d = clk_cnt_q;
        rstn_d    = rstn_q;
        fin_d     = 1'b0;
        evt_en    = 1'b0;
        evt_clr   = 1'b0;
        hit_cyc   = 1'b0;
        hit_evt   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start_i) begin
                    state_d   = ST_RESET;
                    phase_d   = '0;
                    clk_cnt_d = '0;
                    cause_d   = CAUSE_NONE;
                    rstn_d    = 1'b0;
                    evt_clr   = 1'b1;
                end
            end
            ST_RESET: begin
                if (bus.abort_i) begin
                    state_d = ST_DRAIN;
                    cause_d = CAUSE_ABORT;
                    phase_d = '0;
                end else if (phase_q == RST_LAST) begin
                    state_d = ST_RUN;
                    rstn_d  = 1'b1;
                end else begin
                    phase_d = phase_q + CLK_CNT_W'(1);
                end
            end
            ST_RUN: begin
                // The exiting cycle is still counted, so limits compare the next values.
                evt_en    = 1'b1;
                clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
                hit_cyc   = (MAX_CYCLES != 0) && (clk_cnt_d == MAX_CYC);
                hit_evt   = (MAX_EVENTS != 0) && (evt_nxt == MAX_EVT);
                if (bus.abort_i || hit_evt || hit_cyc) begin
                    state_d = ST_DRAIN;
                    phase_d = '0;
                    if (bus.abort_i)  cause_d = CAUSE_ABORT;
                    else if (hit_evt) cause_d = CAUSE_EVT;
                    else              cause_d = CAUSE_CYC;
                end
            end
            ST_DRAIN: begin
                if (phase_q >= DRAIN_LAST) begin
                    state_d = ST_DONE;
                    fin_d   = bus.is_master_i;
                end else begin
                    phase_d = phase_q + CLK_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            cause_q   <= CAUSE_NONE;
            phase_q   <= '0;
            clk_cnt_q <= '0;
            rstn_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            phase_q   <= phase_d;
            clk_cnt_q <= clk_cnt_d;
            rstn_q    <= rstn_d;
            running_q <= running_d;
            done_q    <= done_d;
            fin_q     <= fin_d;
        end
    end

    assign bus.dut_reset_n_o = rstn_q;
    assign bus.running_o     = running_q;
    assign bus.done_o        = done_q;
    assign bus.finish_req_o  = fin_q;
    assign bus.clk_cnt_o     = clk_cnt_q;
    assign bus.event_cnt_o   = evt_cnt;
    assign bus.end_cause_o   = cause_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl
//   Bench for sim_run_ctrl. Three instances with different limits share one clock:
//   0: RST 11, cycle limit 100, no event limit, drain 4
//   1: RST 3,  no cycle limit, event limit 5,   drain 0
//   2: RST 2,  cycle limit 40, event limit 10,  drain 2
module tb_sim_run_ctrl;

    localparam int RSTP [3] = '{11, 3, 2};
    localparam int MCP  [3] = '{100, 0, 40};
    localparam int MEP  [3] = '{0, 5, 10};
    localparam int DRP  [3] = '{4, 0, 2};

    typedef struct {
        logic [31:0] clk;
        logic [63:0] evt;
        logic [1:0]  cause;
        int          fin_n;
    } exp_t;

    logic        clk = 1'b0;
    logic [2:0]  rst_r, start_r, abort_r, master_r, bench_r;
    logic [2:0]  rstn, run, done, fin;
    logic [31:0] clk_cnt [3];
    logic [63:0] evt_cnt [3];
    logic [1:0]  cause   [3];

    exp_t sbq [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sim_run_ctrl_if bus ();
        assign bus.start_i     = start_r[g];
        assign bus.abort_i     = abort_r[g];
        assign bus.is_master_i = master_r[g];
        assign bus.benchmark_i = bench_r[g];
        assign rstn[g]         = bus.dut_reset_n_o;
        assign run[g]          = bus.running_o;
        assign done[g]         = bus.done_o;
        assign fin[g]          = bus.finish_req_o;
        assign clk_cnt[g]      = bus.clk_cnt_o;
        assign evt_cnt[g]      = bus.event_cnt_o;
        assign cause[g]        = bus.end_cause_o;

        sim_run_ctrl #(
            .RST_CYCLES   (RSTP[g]),
            .MAX_CYCLES   (MCP[g]),
            .MAX_EVENTS   (MEP[g]),
            .DRAIN_CYCLES (DRP[g])
        ) u_dut (
            .clk_i   (clk),
            .reset_i (rst_r[g]),
            .bus     (bus.slave)
        );
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    // r = clocks since the DUT entered RUN (r=1 is the first counted edge)
    function automatic logic pat_val(input int pat, input int r);
        if (r <= 0) return 1'b0;
        case (pat)
            1:       return ((r % 4) == 1) || ((r % 4) == 2);
            2:       return (r <= 20) ? 1'b1 : ((r % 2) == 0);
            3:       return (r % 4) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_run(input int d, input int pat, input int abort_at, input bit mst,
                          input bit chk_rel, input logic [31:0] e_clk, input logic [63:0] e_evt,
                          input logic [1:0] e_cause, input int e_fin_n, input string tag);
        exp_t e;
        int   fin_cnt = 0;
        int   fin_at  = -1;
        bit   seen    = 1'b0;
        e.clk = e_clk; e.evt = e_evt; e.cause = e_cause; e.fin_n = e_fin_n;
        sbq.push_back(e);
        master_r[d] = mst;
        for (int n = 0; n < 600 && !seen; n++) begin
            @(negedge clk);
            start_r[d] = (n == 0);
            abort_r[d] = (n == abort_at);
            bench_r[d] = pat_val(pat, n - RSTP[d]);
            @(posedge clk); #1;
            if (fin[d]) begin
                fin_cnt++;
                if (fin_at < 0) fin_at = n;
            end
            if (chk_rel && n == RSTP[d] - 1) begin
                chk({tag, "_rstn_held"}, rstn[d], 1'b0);
                chk({tag, "_run_before"}, run[d], 1'b0);
            end
            if (chk_rel && n == RSTP[d]) begin
                chk({tag, "_rstn_rel"}, rstn[d], 1'b1);
                chk({tag, "_run_start"}, run[d], 1'b1);
            end
            if (done[d]) seen = 1'b1;
        end
        repeat (3) begin
            @(negedge clk);
            start_r[d] = 1'b0;
            abort_r[d] = 1'b0;
            bench_r[d] = 1'b0;
            @(posedge clk); #1;
            if (fin[d]) fin_cnt++;
        end
        chk({tag, "_done_seen"}, seen, 1'b1);
        e = sbq.pop_front();
        chk({tag, "_done_held"}, done[d], 1'b1);
        chk({tag, "_clk_cnt"}, clk_cnt[d], e.clk);
        chk({tag, "_evt_cnt"}, evt_cnt[d], e.evt);
        chk({tag, "_cause"}, cause[d], e.cause);
        chk({tag, "_fin_pulses"}, fin_cnt, (e.fin_n < 0) ? 0 : 1);
        chk({tag, "_fin_at"}, 64'(fin_at), 64'(e.fin_n));
    endtask

    task automatic reset_mid_run();
        int fin_cnt = 0;
        master_r[0] = 1'b1;
        for (int n = 0; n <= 62; n++) begin
            @(negedge clk);
            start_r[0] = (n == 0);
            bench_r[0] = pat_val(1, n - RSTP[0]);
            rst_r[0]   = (n == 62);
            @(posedge clk); #1;
            if (fin[0]) fin_cnt++;
            if (n == 61) chk("mid_clk_before", clk_cnt[0], 50);
        end
        chk("mid_rstn", rstn[0], 1'b0);
        chk("mid_running", run[0], 1'b0);
        chk("mid_done", done[0], 1'b0);
        chk("mid_fin", fin[0], 1'b0);
        chk("mid_clk_cnt", clk_cnt[0], 0);
        chk("mid_evt_cnt", evt_cnt[0], 0);
        chk("mid_cause", cause[0], 0);
        repeat (10) begin
            @(negedge clk);
            rst_r[0]   = 1'b0;
            bench_r[0] = 1'b0;
            @(posedge clk); #1;
            if (fin[0] || done[0] || run[0]) fin_cnt++;
        end
        chk("mid_no_fin_after", fin_cnt, 0);
        chk("mid_idle_clk", clk_cnt[0], 0);
    endtask

    initial begin
        rst_r    = 3'b111;
        start_r  = '0;
        abort_r  = '0;
        master_r = '0;
        bench_r  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rstn", rstn[0], 1'b0);
        chk("rst_running", run[0], 1'b0);
        chk("rst_done", done[0], 1'b0);
        chk("rst_fin", fin[0], 1'b0);
        chk("rst_clk_cnt", clk_cnt[0], 0);
        chk("rst_evt_cnt", evt_cnt[0], 0);
        chk("rst_cause", cause[0], 0);
        chk("rst_done_all", {done[2], done[1]}, 2'b00);
        @(negedge clk);
        rst_r = '0;

        do_run(0, 1, -1, 1'b1, 1'b1, 100, 25, 2'd1, 115, "cyc_lim");
        do_run(0, 0, -1, 1'b0, 1'b1, 100, 0,  2'd1, -1,  "no_master");
        do_run(0, 0, 5,  1'b1, 1'b0, 0,   0,  2'd3, 9,   "abort_rst");
        reset_mid_run();
        do_run(0, 1, -1, 1'b1, 1'b1, 100, 25, 2'd1, 115, "restart");
        do_run(1, 2, -1, 1'b1, 1'b1, 28,  5,  2'd2, 32,  "evt_lim");
        do_run(2, 3, -1, 1'b1, 1'b1, 40,  10, 2'd2, 44,  "evt_cyc_tie");
        do_run(2, 3, 42, 1'b1, 1'b1, 40,  10, 2'd3, 44,  "abort_tie");
        do_run(2, 3, 12, 1'b1, 1'b1, 10,  2,  2'd3, 14,  "abort_run");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
